// File: rtl/inst_fetch_buffer_pkg.sv
// Shared fetch definitions: FSM state encoding, NOP word and FIFO entry layout.
package inst_fetch_buffer_pkg;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } fetch_state_e;

   localparam logic [31:0] INST_NOP      = 32'h0000_0013;
   localparam int unsigned FETCH_ENTRY_W = 64;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_buffer_fifo.sv
// fetch_fifo: synchronous DEPTH x WIDTH FIFO with flush; pop is ignored when empty.
module fetch_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok, pop_ok;

   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign head_data = mem_q[rd_ptr_q];
   assign push_ok   = push && (count_q != (AW+1)'(DEPTH));
   assign pop_ok    = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/inst_fetch_buffer.sv
// Fetch front end: PC register, single-outstanding I-cache request FSM with
// credit check, and a {pc, inst} FIFO feeding decode; redirects flush everything.
module inst_fetch_buffer
   import inst_fetch_buffer_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        icache_req_valid,
   input  logic        icache_req_ready,
   output logic [31:0] icache_req_addr,
   input  logic        icache_resp_valid,
   input  logic [31:0] icache_resp_data,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fetch_state_e   state_q, state_d;
   logic [31:0]    pc_q, pc_d;
   logic [31:0]    req_pc_q, req_pc_d;
   logic           push, pop, flush, empty;
   logic           outstanding, credit_ok, req_fire;
   logic [CW-1:0]  count;
   fetch_entry_t   push_entry, head_entry;

   assign outstanding      = (state_q != S_REQ);
   assign credit_ok        = (32'(count) + 32'(outstanding)) < DEPTH;
   assign icache_req_valid = !reset && (state_q == S_REQ) && credit_ok;
   assign icache_req_addr  = pc_q;
   assign req_fire         = icache_req_valid && icache_req_ready;

   assign push_entry.pc    = req_pc_q;
   assign push_entry.inst  = icache_resp_data;

   assign id_valid = !empty;
   assign id_inst  = empty ? INST_NOP : head_entry.inst;
   assign id_pc    = empty ? 32'h0 : head_entry.pc;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      push     = 1'b0;
      pop      = id_valid && id_ready;
      flush    = 1'b0;
      case (state_q)
         S_REQ: begin
            if (req_fire) begin
               req_pc_d = pc_q;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (icache_resp_valid) begin
               push    = 1'b1;
               pc_d    = pc_q + 32'd4;
               state_d = S_REQ;
            end
         end
         S_DROP: begin
            if (icache_resp_valid) state_d = S_REQ;
         end
         default: state_d = S_REQ;
      endcase
      // Redirect overrides the above: only whether a response is still owed decides S_DROP vs S_REQ.
      if (redirect_valid) begin
         flush = 1'b1;
         push  = 1'b0;
         pop   = 1'b0;
         pc_d  = redirect_pc & 32'hFFFF_FFFC;
         if ((state_q == S_REQ && req_fire) || (state_q != S_REQ && !icache_resp_valid))
            state_d = S_DROP;
         else
            state_d = S_REQ;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_REQ;
         pc_q     <= RESET_PC;
         req_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FETCH_ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head_data (head_entry),
      .empty     (empty),
      .count     (count)
   );

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer: cycle table for the main flows plus
// hand sequences for reset-in-flight and a wrapping RESET_PC instance.
module tb_inst_fetch_buffer;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        rr, rv, ir, xv;
   logic [31:0] rd, xp;
   logic        qv, iv;
   logic [31:0] qa, ipc, iinst;

   logic        b_rr, b_rv, b_ir, b_xv;
   logic [31:0] b_rd, b_xp;
   logic        b_qv, b_iv;
   logic [31:0] b_qa, b_ipc, b_iinst;

   int total = 0;
   int bad   = 0;

   inst_fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset),
      .icache_req_valid(qv), .icache_req_ready(rr), .icache_req_addr(qa),
      .icache_resp_valid(rv), .icache_resp_data(rd),
      .id_valid(iv), .id_ready(ir), .id_inst(iinst), .id_pc(ipc),
      .redirect_valid(xv), .redirect_pc(xp)
   );

   inst_fetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clk(clk), .reset(reset),
      .icache_req_valid(b_qv), .icache_req_ready(b_rr), .icache_req_addr(b_qa),
      .icache_resp_valid(b_rv), .icache_resp_data(b_rd),
      .id_valid(b_iv), .id_ready(b_ir), .id_inst(b_iinst), .id_pc(b_ipc),
      .redirect_valid(b_xv), .redirect_pc(b_xp)
   );

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'h5A5A_0013;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rr, rv;
      logic [31:0] rd;
      logic        ir, xv;
      logic [31:0] xp;
      logic        qv;
      logic [31:0] qa;
      logic        iv;
      logic [31:0] ipc;
   } vec_t;

   vec_t vecs [41];

   function automatic vec_t v(input logic r_rr, input logic r_rv, input logic [31:0] r_rd,
                              input logic r_ir, input logic r_xv, input logic [31:0] r_xp,
                              input logic e_qv, input logic [31:0] e_qa,
                              input logic e_iv, input logic [31:0] e_ipc);
      vec_t t;
      t.rr = r_rr; t.rv = r_rv; t.rd = r_rd; t.ir = r_ir; t.xv = r_xv; t.xp = r_xp;
      t.qv = e_qv; t.qa = e_qa; t.iv = e_iv; t.ipc = e_ipc;
      return t;
   endfunction

   // Per-cycle protocol monitor on the main instance.
   logic        hold_prev = 1'b0;
   logic [31:0] addr_prev = '0;
   logic        outst     = 1'b0;
   always begin
      @(negedge clk);
      #3;
      if (hold_prev) begin
         chk("req_stable_valid", {31'b0, qv}, 32'd1);
         chk("req_stable_addr", qa, addr_prev);
      end
      if (qv) chk("req_single_outstanding", {31'b0, outst}, 32'd0);
      hold_prev = qv && !rr && !xv && !reset;
      addr_prev = qa;
      if (reset)            outst = 1'b0;
      else if (qv && rr)    outst = 1'b1;
      else if (rv)          outst = 1'b0;
   end

   task automatic chk_id(input string tag, input logic e_iv, input logic [31:0] e_pc);
      chk({tag, "_id_valid"}, {31'b0, iv}, {31'b0, e_iv});
      chk({tag, "_id_pc"}, ipc, e_iv ? e_pc : 32'h0);
      chk({tag, "_id_inst"}, iinst, e_iv ? mem(e_pc) : NOP);
   endtask

   task automatic drive(input logic i_rr, input logic i_rv, input logic [31:0] i_rd,
                        input logic i_ir, input logic i_xv, input logic [31:0] i_xp);
      rr = i_rr; rv = i_rv; rd = i_rd; ir = i_ir; xv = i_xv; xp = i_xp;
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      b_rr = 0; b_rv = 0; b_rd = 0; b_ir = 0; b_xv = 0; b_xp = 0;

      vecs[0]  = v(1,0,0,1,0,0,            1,32'h0,  0,0);
      vecs[1]  = v(0,1,mem(32'h0),1,0,0,   0,0,      0,0);
      vecs[2]  = v(1,0,0,1,0,0,            1,32'h4,  1,32'h0);
      vecs[3]  = v(0,1,mem(32'h4),1,0,0,   0,0,      0,0);
      vecs[4]  = v(1,0,0,1,0,0,            1,32'h8,  1,32'h4);
      vecs[5]  = v(0,1,mem(32'h8),1,0,0,   0,0,      0,0);
      vecs[6]  = v(0,0,0,1,0,0,            1,32'hC,  1,32'h8);
      vecs[7]  = v(1,0,0,1,0,0,            1,32'hC,  0,0);
      vecs[8]  = v(0,0,0,1,0,0,            0,0,      0,0);
      vecs[9]  = v(0,1,mem(32'hC),1,0,0,   0,0,      0,0);
      vecs[10] = v(1,0,0,0,0,0,            1,32'h10, 1,32'hC);
      vecs[11] = v(0,1,mem(32'h10),0,0,0,  0,0,      1,32'hC);
      vecs[12] = v(1,0,0,0,0,0,            1,32'h14, 1,32'hC);
      vecs[13] = v(0,1,mem(32'h14),0,0,0,  0,0,      1,32'hC);
      vecs[14] = v(1,0,0,0,0,0,            1,32'h18, 1,32'hC);
      vecs[15] = v(0,1,mem(32'h18),0,0,0,  0,0,      1,32'hC);
      vecs[16] = v(1,0,0,0,0,0,            0,0,      1,32'hC);
      vecs[17] = v(0,0,0,1,0,0,            0,0,      1,32'hC);
      vecs[18] = v(0,0,0,1,0,0,            1,32'h1C, 1,32'h10);
      vecs[19] = v(0,0,0,1,0,0,            1,32'h1C, 1,32'h14);
      vecs[20] = v(0,0,0,1,0,0,            1,32'h1C, 1,32'h18);
      vecs[21] = v(1,0,0,0,0,0,            1,32'h1C, 0,0);
      vecs[22] = v(0,0,0,0,1,32'h100,      0,0,      0,0);
      vecs[23] = v(0,0,0,0,0,0,            0,0,      0,0);
      vecs[24] = v(0,1,mem(32'h1C),0,0,0,  0,0,      0,0);
      vecs[25] = v(1,0,0,0,0,0,            1,32'h100,0,0);
      vecs[26] = v(0,1,mem(32'h100),0,0,0, 0,0,      0,0);
      vecs[27] = v(1,0,0,0,0,0,            1,32'h104,1,32'h100);
      vecs[28] = v(0,1,mem(32'h104),1,1,32'h200, 0,0, 1,32'h100);
      vecs[29] = v(1,0,0,1,1,32'h300,      1,32'h200,0,0);
      vecs[30] = v(0,1,mem(32'h200),1,0,0, 0,0,      0,0);
      vecs[31] = v(1,0,0,1,0,0,            1,32'h300,0,0);
      vecs[32] = v(0,1,mem(32'h300),0,0,0, 0,0,      0,0);
      vecs[33] = v(0,0,0,0,1,32'h103,      1,32'h304,1,32'h300);
      vecs[34] = v(1,0,0,0,0,0,            1,32'h100,0,0);
      vecs[35] = v(0,0,0,0,1,32'h40,       0,0,      0,0);
      vecs[36] = v(0,0,0,0,1,32'h80,       0,0,      0,0);
      vecs[37] = v(0,1,32'hDEAD_BEEF,0,0,0,0,0,      0,0);
      vecs[38] = v(1,0,0,0,0,0,            1,32'h80, 0,0);
      vecs[39] = v(0,1,mem(32'h80),0,0,0,  0,0,      0,0);
      vecs[40] = v(0,0,0,1,0,0,            1,32'h84, 1,32'h80);

      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_req_valid", {31'b0, qv}, 32'd0);
      chk_id("rst", 1'b0, 32'h0);
      chk("rst_wrap_req_valid", {31'b0, b_qv}, 32'd0);

      for (int i = 0; i < 41; i++) begin
         @(negedge clk);
         reset = 1'b0;
         drive(vecs[i].rr, vecs[i].rv, vecs[i].rd, vecs[i].ir, vecs[i].xv, vecs[i].xp);
         #1;
         chk($sformatf("v%0d_req_valid", i), {31'b0, qv}, {31'b0, vecs[i].qv});
         if (vecs[i].qv) chk($sformatf("v%0d_req_addr", i), qa, vecs[i].qa);
         chk_id($sformatf("v%0d", i), vecs[i].iv, vecs[i].ipc);
      end

      // Reset while waiting on a response with three entries buffered.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); drive(1, 0, 0, 0, 0, 0); #1;
         chk($sformatf("fill%0d_req_addr", k), qa, 32'h84 + 32'(4 * k));
         @(negedge clk); drive(0, 1, mem(32'h84 + 32'(4 * k)), 0, 0, 0);
      end
      @(negedge clk); drive(1, 0, 0, 0, 0, 0); #1;
      chk("fill_req_addr", qa, 32'h90);
      chk_id("fill_head", 1'b1, 32'h84);
      @(negedge clk); reset = 1'b1; drive(0, 1, 32'h1234_5678, 1, 1, 32'h500);
      @(negedge clk); drive(0, 0, 0, 0, 0, 0); #1;
      chk("mid_rst_req_valid", {31'b0, qv}, 32'd0);
      chk_id("mid_rst", 1'b0, 32'h0);
      @(negedge clk); reset = 1'b0; drive(0, 1, 32'hBAD0_BAD0, 1, 0, 0); #1;
      chk("post_rst_req_valid", {31'b0, qv}, 32'd1);
      chk("post_rst_req_addr", qa, 32'h0);
      @(negedge clk); drive(1, 0, 0, 1, 0, 0); #1;
      chk_id("post_rst_stale", 1'b0, 32'h0);
      chk("post_rst_req_addr2", qa, 32'h0);
      @(negedge clk); drive(0, 1, mem(32'h0), 1, 0, 0);
      @(negedge clk); drive(0, 0, 0, 0, 0, 0); #1;
      chk_id("post_rst_first", 1'b1, 32'h0);

      // Wrapping PC on the second instance, then a misaligned redirect.
      for (int k = 0; k < 3; k++) begin
         logic [31:0] a;
         a = 32'hFFFF_FFF8 + 32'(4 * k);
         @(negedge clk);
         b_rr = 1; b_rv = 0; b_ir = 1; #1;
         chk($sformatf("wrap%0d_req_valid", k), {31'b0, b_qv}, 32'd1);
         chk($sformatf("wrap%0d_req_addr", k), b_qa, a);
         if (k > 0) chk($sformatf("wrap%0d_prev_pc", k), b_ipc, a - 32'd4);
         @(negedge clk);
         b_rr = 0; b_rv = 1; b_rd = mem(a);
      end
      @(negedge clk);
      b_rv = 0; b_xv = 1; b_xp = 32'h103; #1;
      chk("wrap_last_valid", {31'b0, b_iv}, 32'd1);
      chk("wrap_last_pc", b_ipc, 32'h0);
      chk("wrap_last_inst", b_iinst, mem(32'h0));
      @(negedge clk);
      b_xv = 0; b_ir = 0; #1;
      chk("wrap_redir_req_addr", b_qa, 32'h100);
      chk("wrap_redir_id_valid", {31'b0, b_iv}, 32'd0);

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
